// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding and sizing helpers for the UART receiver
package uart_rx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
  localparam int OVERSAMPLE_DEF = 16;
  function automatic int mid_of(input int os);
    return os / 2 - 1;
  endfunction
  function automatic int bit_cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction
endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// uart_rx_edge_bit_counter: oversample tick counter with mid/wrap flags and per-frame bit counter
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_i,
  input  logic                             advance_i,
  output logic                             mid_o,
  output logic                             wrap_o,
  output logic [bit_cnt_w(DATA_WIDTH)-1:0] bit_cnt_o
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = bit_cnt_w(DATA_WIDTH);
  logic [TW-1:0] tick_q;
  logic [BW-1:0] bit_q;
  assign mid_o     = tick_q == TW'(mid_of(OVERSAMPLE));
  assign wrap_o    = tick_q == TW'(OVERSAMPLE - 1);
  assign bit_cnt_o = bit_q;
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      tick_q <= '0;
      bit_q  <= '0;
    end else if (advance_i) begin
      tick_q <= tick_q + 1'b1;
      bit_q  <= bit_q + BW'(wrap_o);
    end
  end
endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: oversampling UART receive FSM producing sample strobes and frame status pulses
module uart_rx_controller
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic UCLK,
  input  logic reset,
  input  logic rx_in,
  input  logic parity_en,
  input  logic parity_bit_error,
  output logic sampled_bit,
  output logic deser_en,
  output logic par_chk_en,
  output logic data_valid,
  output logic frame_error,
  output logic parity_error,
  output logic busy
);
  localparam int BW = bit_cnt_w(DATA_WIDTH);
  state_e state_q, state_d;
  logic par_q, mid, wrap, clear, stop_mid, perr;
  logic [BW-1:0] bit_cnt;
  uart_rx_edge_bit_counter #(.DATA_WIDTH(DATA_WIDTH), .OVERSAMPLE(OVERSAMPLE)) u_cnt (
    .clk       (UCLK),
    .rst       (reset),
    .clear_i   (clear),
    .advance_i (state_q != ST_IDLE),
    .mid_o     (mid),
    .wrap_o    (wrap),
    .bit_cnt_o (bit_cnt)
  );
  assign state_d = state_q == ST_IDLE   ? (rx_in ? ST_IDLE : ST_START) :
                   state_q == ST_START  ? (mid && rx_in ? ST_IDLE : wrap ? ST_DATA : ST_START) :
                   state_q == ST_DATA   ? (wrap && bit_cnt == BW'(DATA_WIDTH - 1) ?
                                           (par_q ? ST_PARITY : ST_STOP) : ST_DATA) :
                   state_q == ST_PARITY ? (wrap ? ST_STOP : ST_PARITY) :
                                          (mid ? ST_IDLE : ST_STOP);
  assign clear    = state_q == ST_IDLE || state_d == ST_IDLE || (state_q == ST_START && wrap);
  assign stop_mid = state_q == ST_STOP && mid;
  assign perr     = par_q && parity_bit_error;
  assign busy     = state_q != ST_IDLE;
  always_ff @(posedge UCLK) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      par_q        <= 1'b0;
      sampled_bit  <= 1'b0;
      deser_en     <= 1'b0;
      par_chk_en   <= 1'b0;
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      state_q      <= state_d;
      par_q        <= state_q == ST_IDLE && !rx_in ? parity_en : par_q;
      sampled_bit  <= mid ? rx_in : sampled_bit;
      deser_en     <= state_q == ST_DATA && mid;
      par_chk_en   <= state_q == ST_PARITY && mid;
      frame_error  <= stop_mid && !rx_in;
      parity_error <= stop_mid && perr;
      data_valid   <= stop_mid && rx_in && !perr;
    end
  end
endmodule
